// File: rtl/tap_loader.sv
// ============================================================================
//  Module   : tap_loader
//  Brief    : Lynx machine-code tape image parser; writes payload to RAM port B
//             and pulses tape_complete with the exec address on tape_addr.
//             Optional trailing checksum byte: TAP_LOADER_CSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tap_loader #(
    parameter logic [7:0] TAP_INDEX = 8'd1,
    parameter int         MAX_NAME  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [15:0] tape_addr,
    output logic [7:0]  tape_dout,
    output logic        tape_wr,
    output logic        tape_complete,
    output logic        busy,
    output logic        error
);

    localparam logic [7:0] QUOTE      = 8'h22;
    localparam logic [7:0] TYPE_M     = 8'h4D;
    localparam logic [7:0] NAME_LIMIT = 8'(MAX_NAME);

    typedef enum logic [3:0] {
        S_IDLE, S_NAME_OPEN, S_NAME, S_TYPE, S_LOAD_LO, S_LOAD_HI, S_LEN_LO,
        S_LEN_HI, S_DATA, S_EXEC_LO, S_EXEC_HI, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d, eff_state;
    logic [7:0]  name_cnt_q, name_cnt_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] tape_addr_q, tape_addr_d;
    logic [7:0]  tape_dout_q, tape_dout_d;
    logic        tape_wr_q, tape_wr_d;
    logic        complete_q, complete_d;
`ifdef TAP_LOADER_CSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic accept;
    logic active;

    assign accept = ioctl_download && ioctl_wr && (ioctl_index == TAP_INDEX);
    assign active = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            name_cnt_q  <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            tape_addr_q <= '0;
            tape_dout_q <= '0;
            tape_wr_q   <= 1'b0;
            complete_q  <= 1'b0;
`ifdef TAP_LOADER_CSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            name_cnt_q  <= name_cnt_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            tape_addr_q <= tape_addr_d;
            tape_dout_q <= tape_dout_d;
            tape_wr_q   <= tape_wr_d;
            complete_q  <= complete_d;
`ifdef TAP_LOADER_CSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        name_cnt_d  = name_cnt_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        tape_addr_d = tape_addr_q;
        tape_dout_d = tape_dout_q;
        tape_wr_d   = 1'b0;
        complete_d  = 1'b0;
`ifdef TAP_LOADER_CSUM_EN
        sum_d       = sum_q;
`endif
        // A byte at offset 0 (or the first byte seen from IDLE) always opens a new image.
        eff_state = ((ioctl_addr == '0) || (state_q == S_IDLE)) ? S_NAME_OPEN : state_q;

        if (!ioctl_download && active) begin
            state_d = S_ERROR;
        end else if (accept) begin
            case (eff_state)
                S_NAME_OPEN: begin
                    name_cnt_d = '0;
`ifdef TAP_LOADER_CSUM_EN
                    sum_d      = '0;
`endif
                    state_d    = (ioctl_dout == QUOTE) ? S_NAME : S_ERROR;
                end
                S_NAME: begin
                    if (ioctl_dout == QUOTE) begin
                        state_d = S_TYPE;
                    end else begin
                        name_cnt_d = name_cnt_q + 8'd1;
                        if (name_cnt_q >= NAME_LIMIT) state_d = S_ERROR;
                    end
                end
                S_TYPE:    state_d = (ioctl_dout == TYPE_M) ? S_LOAD_LO : S_ERROR;
                S_LOAD_LO: begin ptr_d[7:0]  = ioctl_dout; state_d = S_LOAD_HI; end
                S_LOAD_HI: begin ptr_d[15:8] = ioctl_dout; state_d = S_LEN_LO;  end
                S_LEN_LO:  begin rem_d[7:0]  = ioctl_dout; state_d = S_LEN_HI;  end
                S_LEN_HI: begin
                    rem_d[15:8] = ioctl_dout;
                    state_d     = ({ioctl_dout, rem_q[7:0]} == 16'h0000) ? S_EXEC_LO : S_DATA;
                end
                S_DATA: begin
                    tape_addr_d = ptr_q;
                    tape_dout_d = ioctl_dout;
                    tape_wr_d   = 1'b1;
                    ptr_d       = ptr_q + 16'd1;
                    rem_d       = rem_q - 16'd1;
`ifdef TAP_LOADER_CSUM_EN
                    sum_d       = sum_q + ioctl_dout;
`endif
                    if (rem_q == 16'd1) state_d = S_EXEC_LO;
                end
                // The load pointer is free after DATA, so it holds the exec address.
                S_EXEC_LO: begin ptr_d[7:0] = ioctl_dout; state_d = S_EXEC_HI; end
`ifdef TAP_LOADER_CSUM_EN
                S_EXEC_HI: begin ptr_d[15:8] = ioctl_dout; state_d = S_CSUM; end
                S_CSUM: begin
                    if (ioctl_dout == sum_q) begin
                        tape_addr_d = ptr_q;
                        complete_d  = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d     = S_ERROR;
                    end
                end
`else
                S_EXEC_HI: begin
                    tape_addr_d = {ioctl_dout, ptr_q[7:0]};
                    complete_d  = 1'b1;
                    state_d     = S_DONE;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    assign tape_addr     = tape_addr_q;
    assign tape_dout     = tape_dout_q;
    assign tape_wr       = tape_wr_q;
    assign tape_complete = complete_q;
    assign busy          = active;
    assign error         = (state_q == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_tap_loader.sv
// ============================================================================
//  Module   : tb_tap_loader
//  Brief    : Directed self-checking bench for tap_loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tap_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = 8'd1;
    logic [15:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        tape_wr;
    logic        tape_complete;
    logic        busy;
    logic        error;

    tap_loader dut (
        .clock          (clock),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .tape_addr      (tape_addr),
        .tape_dout      (tape_dout),
        .tape_wr        (tape_wr),
        .tape_complete  (tape_complete),
        .busy           (busy),
        .error          (error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Write/complete observer, sampled on the falling edge
    int          wr_total  = 0;
    int          cmp_total = 0;
    logic [15:0] wr_addr_log [256];
    logic [7:0]  wr_data_log [256];
    logic [15:0] cmp_addr_last = '0;
    logic        both_seen = 1'b0;

    always @(negedge clock) begin
        if (tape_wr === 1'b1) begin
            wr_addr_log[wr_total % 256] = tape_addr;
            wr_data_log[wr_total % 256] = tape_dout;
            wr_total = wr_total + 1;
        end
        if (tape_complete === 1'b1) begin
            cmp_addr_last = tape_addr;
            cmp_total = cmp_total + 1;
        end
        if (tape_wr === 1'b1 && tape_complete === 1'b1) both_seen = 1'b1;
    end

    logic [7:0] img[$];

    task automatic build(input int nlen, input logic [7:0] typ, input logic [15:0] load,
                         input logic [15:0] len, input logic [7:0] d0,
                         input logic [15:0] exec, input logic [7:0] csum_adj);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
        img.delete();
        img.push_back(8'h22);
        for (int i = 0; i < nlen; i++) img.push_back(8'h41);
        img.push_back(8'h22);
        img.push_back(typ);
        img.push_back(load[7:0]);
        img.push_back(load[15:8]);
        img.push_back(len[7:0]);
        img.push_back(len[15:8]);
        for (int k = 0; k < int'(len); k++) begin
            b = d0 + 8'(k * 8'h11);
            sum = sum + b;
            img.push_back(b);
        end
        img.push_back(exec[7:0]);
        img.push_back(exec[15:8]);
`ifdef TAP_LOADER_CSUM_EN
        img.push_back(sum + csum_adj);
`else
        if (csum_adj != 8'h00) sum = sum + csum_adj;
`endif
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = img[i];
            @(negedge clock);
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic finish_dl();
        @(negedge clock);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic run_image();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        send_range(0, img.size() - 1);
        finish_dl();
    endtask

    task automatic check_outputs_zero(input string tag);
        n_cmp++; if (tape_addr !== 16'h0) begin n_bad++; $display("FAIL %s tape_addr: got %h need 0000", tag, tape_addr); end
        n_cmp++; if (tape_dout !== 8'h0) begin n_bad++; $display("FAIL %s tape_dout: got %h need 00", tag, tape_dout); end
        n_cmp++; if (tape_wr !== 1'b0) begin n_bad++; $display("FAIL %s tape_wr: got %b need 0", tag, tape_wr); end
        n_cmp++; if (tape_complete !== 1'b0) begin n_bad++; $display("FAIL %s tape_complete: got %b need 0", tag, tape_complete); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b need 0", tag, busy); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL %s error: got %b need 0", tag, error); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int w0, c0;
        w0 = wr_total; c0 = cmp_total;
        build(1, 8'h4D, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h00);
        ioctl_download = 1'b1;
        send_range(0, 5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic busy mid-load: got %b need 1", busy); end
        send_range(6, img.size() - 1);
        finish_dl();
        n_cmp++; if (wr_total - w0 !== 3) begin n_bad++; $display("FAIL basic write count: got %0d need 3", wr_total - w0); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (wr_addr_log[(w0 + k) % 256] !== 16'h4000 + 16'(k) ||
                wr_data_log[(w0 + k) % 256] !== 8'h11 * 8'(k + 1)) begin
                n_bad++;
                $display("FAIL basic write %0d: got %h@%h need %h@%h", k, wr_data_log[(w0 + k) % 256],
                         wr_addr_log[(w0 + k) % 256], 8'h11 * 8'(k + 1), 16'h4000 + 16'(k));
            end
        end
        n_cmp++; if (cmp_total - c0 !== 1) begin n_bad++; $display("FAIL basic complete count: got %0d need 1", cmp_total - c0); end
        n_cmp++; if (cmp_addr_last !== 16'h4000) begin n_bad++; $display("FAIL basic exec: got %h need 4000", cmp_addr_last); end
        n_cmp++; if (tape_addr !== 16'h4000) begin n_bad++; $display("FAIL basic hold exec: got %h need 4000", tape_addr); end
        n_cmp++; if (error !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic end flags: got err=%b busy=%b need 0 0", error, busy); end
    endtask

    task automatic test_zero_len();
        int w0, c0;
        w0 = wr_total; c0 = cmp_total;
        build(2, 8'h4D, 16'h6000, 16'd0, 8'h00, 16'h1234, 8'h00);
        run_image();
        n_cmp++; if (wr_total - w0 !== 0) begin n_bad++; $display("FAIL zerolen writes: got %0d need 0", wr_total - w0); end
        n_cmp++; if (cmp_total - c0 !== 1 || cmp_addr_last !== 16'h1234) begin n_bad++;
            $display("FAIL zerolen complete: got n=%0d addr=%h need n=1 addr=1234", cmp_total - c0, cmp_addr_last); end
    endtask

    task automatic test_wrap();
        int w0, c0;
        w0 = wr_total; c0 = cmp_total;
        build(1, 8'h4D, 16'hFFFE, 16'd3, 8'hAA, 16'h0000, 8'h00);
        run_image();
        n_cmp++;
        if (wr_total - w0 !== 3 ||
            wr_addr_log[w0 % 256] !== 16'hFFFE || wr_data_log[w0 % 256] !== 8'hAA ||
            wr_addr_log[(w0 + 1) % 256] !== 16'hFFFF || wr_data_log[(w0 + 1) % 256] !== 8'hBB ||
            wr_addr_log[(w0 + 2) % 256] !== 16'h0000 || wr_data_log[(w0 + 2) % 256] !== 8'hCC) begin
            n_bad++;
            $display("FAIL wrap writes: got n=%0d last %h@%h need AA@FFFE BB@FFFF CC@0000",
                     wr_total - w0, wr_data_log[(w0 + 2) % 256], wr_addr_log[(w0 + 2) % 256]);
        end
        n_cmp++; if (error !== 1'b0 || cmp_total - c0 !== 1) begin n_bad++;
            $display("FAIL wrap end: got err=%b n=%0d need err=0 n=1", error, cmp_total - c0); end
    endtask

    task automatic test_bad_type();
        int w0, c0;
        w0 = wr_total; c0 = cmp_total;
        build(1, 8'h42, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h00);
        run_image();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL badtype error: got %b need 1", error); end
        n_cmp++; if (wr_total - w0 !== 0 || cmp_total - c0 !== 0) begin n_bad++;
            $display("FAIL badtype activity: got wr=%0d cmp=%0d need 0 0", wr_total - w0, cmp_total - c0); end
        c0 = cmp_total;
        build(1, 8'h4D, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h00);
        run_image();
        n_cmp++; if (error !== 1'b0 || cmp_total - c0 !== 1) begin n_bad++;
            $display("FAIL badtype recover: got err=%b cmp=%0d need 0 1", error, cmp_total - c0); end
    endtask

    task automatic test_name_len();
        int c0;
        c0 = cmp_total;
        build(16, 8'h4D, 16'h5000, 16'd1, 8'h55, 16'h5000, 8'h00);
        run_image();
        n_cmp++; if (error !== 1'b0 || cmp_total - c0 !== 1) begin n_bad++;
            $display("FAIL name16: got err=%b cmp=%0d need 0 1", error, cmp_total - c0); end
        c0 = cmp_total;
        build(17, 8'h4D, 16'h5000, 16'd1, 8'h55, 16'h5000, 8'h00);
        run_image();
        n_cmp++; if (error !== 1'b1 || cmp_total - c0 !== 0) begin n_bad++;
            $display("FAIL name17: got err=%b cmp=%0d need 1 0", error, cmp_total - c0); end
    endtask

    task automatic test_early_end();
        int w0, c0;
        w0 = wr_total; c0 = cmp_total;
        build(1, 8'h4D, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h00);
        ioctl_download = 1'b1;
        send_range(0, 9);
        finish_dl();
        n_cmp++; if (error !== 1'b1 || busy !== 1'b0) begin n_bad++;
            $display("FAIL early end flags: got err=%b busy=%b need 1 0", error, busy); end
        n_cmp++; if (wr_total - w0 !== 2 || cmp_total - c0 !== 0) begin n_bad++;
            $display("FAIL early end activity: got wr=%0d cmp=%0d need 2 0", wr_total - w0, cmp_total - c0); end
    endtask

    task automatic test_reset_mid();
        build(1, 8'h4D, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h00);
        ioctl_download = 1'b1;
        send_range(0, 9);
        n_cmp++; if (tape_wr !== 1'b1 || tape_addr !== 16'h4001) begin n_bad++;
            $display("FAIL pre-reset write: got wr=%b addr=%h need 1 4001", tape_wr, tape_addr); end
        #1 reset = 1'b0;
        #1 check_outputs_zero("midreset");
        ioctl_download = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ignore();
        int w0;
        w0 = wr_total;
        build(1, 8'h4D, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h00);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd2;
        send_range(0, img.size() - 1);
        ioctl_index    = 8'd1;
        n_cmp++; if (busy !== 1'b0 || wr_total - w0 !== 0) begin n_bad++;
            $display("FAIL wrong index: got busy=%b wr=%0d need 0 0", busy, wr_total - w0); end
        ioctl_download = 1'b0;
        send_range(0, img.size() - 1);
        n_cmp++; if (busy !== 1'b0 || error !== 1'b0 || wr_total - w0 !== 0) begin n_bad++;
            $display("FAIL download low: got busy=%b err=%b wr=%0d need 0 0 0", busy, error, wr_total - w0); end
        repeat (2) @(negedge clock);
    endtask

`ifdef TAP_LOADER_CSUM_EN
    task automatic test_csum();
        int c0;
        c0 = cmp_total;
        build(1, 8'h4D, 16'h4000, 16'd3, 8'h11, 16'h4000, 8'h01);
        run_image();
        n_cmp++; if (error !== 1'b1 || cmp_total - c0 !== 0) begin n_bad++;
            $display("FAIL csum mismatch: got err=%b cmp=%0d need 1 0", error, cmp_total - c0); end
    endtask
`endif

    initial begin
        test_reset();
        test_ignore();
        test_basic();
        test_zero_len();
        test_wrap();
        test_bad_type();
        test_name_len();
        test_early_end();
        test_reset_mid();
`ifdef TAP_LOADER_CSUM_EN
        test_csum();
`endif
        n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL wr/complete overlap: got %b need 0", both_seen); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
